// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Purpose  : Shared RAM geometry, lock-state encoding and index-width helper
//             for the data-RAM arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam int MEM_ADDR_W = 11;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_DEPTH  = 2048;

    typedef enum logic [0:0] {
        LK_UNLOCKED = 1'b0,
        LK_LOCKED   = 1'b1
    } lock_state_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_rr_pick.sv
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin picker: first valid & unmasked
//             requester at or after ptr, as one-hot grant plus index.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick
    import mem_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    input  logic [NREQ-1:0] mask,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            any
);

    int w_j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        w_j   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = int'(ptr) + k;
            if (w_j >= NREQ) w_j = w_j - NREQ;
            if (!any && valid[w_j] && mask[w_j]) begin
                any        = 1'b1;
                grant[w_j] = 1'b1;
                idx        = PW'(w_j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Round-robin sharing of a single-port data RAM among NREQ
//             requesters, one access per clock, response one cycle later.
//             Define MEM_ARB_LOCK_EN to enable the owner-lock FSM.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_wen,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic                     ram_wen,
    output logic [DATA_W-1:0]        ram_din,
    input  logic [DATA_W-1:0]        ram_dout
);

    localparam int PW = idx_w(NREQ);

    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     w_ptr_nxt;
    logic [PW-1:0]     w_idx;
    logic [NREQ-1:0]   w_grant;
    logic [NREQ-1:0]   w_mask;
    logic              w_any;
    logic              w_xfer;
    logic [NREQ-1:0]   r_rsp_tag;
    logic              r_rsp_wr;
    logic [DATA_W-1:0] r_rsp_wdata;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .valid (req_valid),
        .ptr   (r_ptr),
        .mask  (w_mask),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    // Grant is suppressed while reset is held so nothing transfers during reset.
    assign w_xfer    = w_any & rst;
    assign req_ready = rst ? w_grant : '0;
    assign w_ptr_nxt = (int'(w_idx) == NREQ - 1) ? '0 : w_idx + PW'(1);

    always_comb begin
        ram_addr = '0;
        ram_wen  = 1'b0;
        ram_din  = '0;
        if (w_xfer) begin
            ram_addr = req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
            ram_wen  = req_wen[w_idx];
            ram_din  = req_wdata[int'(w_idx)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr       <= '0;
            r_rsp_tag   <= '0;
            r_rsp_wr    <= 1'b0;
            r_rsp_wdata <= '0;
        end else begin
            if (w_xfer) r_ptr <= w_ptr_nxt;
            r_rsp_tag   <= w_xfer ? w_grant : '0;
            r_rsp_wr    <= w_xfer & req_wen[w_idx];
            r_rsp_wdata <= ram_din;
        end
    end

    // Writes answer with the data written rather than whatever the RAM drives.
    assign rsp_valid = r_rsp_tag;
    assign rsp_rdata = (|r_rsp_tag) ? (r_rsp_wr ? r_rsp_wdata : ram_dout) : '0;

`ifdef MEM_ARB_LOCK_EN
    lock_state_t r_lk_state;
    lock_state_t w_lk_state_nxt;
    logic [PW-1:0] r_owner;
    logic [PW-1:0] w_owner_nxt;

    assign w_mask = (r_lk_state == LK_LOCKED) ? (NREQ'(1) << r_owner) : '1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lk_state <= LK_UNLOCKED;
            r_owner    <= '0;
        end else begin
            r_lk_state <= w_lk_state_nxt;
            r_owner    <= w_owner_nxt;
        end
    end

    always_comb begin
        w_lk_state_nxt = r_lk_state;
        w_owner_nxt    = r_owner;
        case (r_lk_state)
            LK_UNLOCKED: begin
                if (w_xfer && req_lock[w_idx]) begin
                    w_lk_state_nxt = LK_LOCKED;
                    w_owner_nxt    = w_idx;
                end
            end
            LK_LOCKED: begin
                if (w_xfer && !req_lock[w_idx]) w_lk_state_nxt = LK_UNLOCKED;
            end
            default: w_lk_state_nxt = LK_UNLOCKED;
        endcase
    end
`else
    logic w_unused_lock;

    assign w_mask        = '1;
    assign w_unused_lock = ^req_lock;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed self-checking bench for mem_arbiter (NREQ=2) with a
//             behavioural 2048x32 RAM; lock cases compile under MEM_ARB_LOCK_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_wen, req_lock, rsp_valid;
    logic [21:0] req_addr;
    logic [63:0] req_wdata;
    logic [31:0] rsp_rdata, ram_din, ram_dout;
    logic [10:0] ram_addr;
    logic        ram_wen;
    logic [31:0] mem [0:2047];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wen) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    mem_arbiter #(.NREQ(2), .ADDR_W(11), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_addr  (ram_addr),
        .ram_wen   (ram_wen),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's requests (called at posedge+1), check mid-cycle, advance.
    task automatic cyc(input string tag, input logic [1:0] v, input logic [1:0] w,
                       input logic [1:0] lk, input logic [10:0] a0, input logic [10:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] e_rdy, input logic [1:0] e_rsp, input logic [31:0] e_dat);
        req_valid = v;
        req_wen   = w;
        req_lock  = lk;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        @(negedge clk);
        check({tag, " ready"}, 64'(req_ready), 64'(e_rdy));
        check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(e_rsp));
        check({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(e_dat));
        @(posedge clk);
        #1;
    endtask

    task automatic reset_now(input string tag, input logic [1:0] e_rsp_before);
        check({tag, " rsp before"}, 64'(rsp_valid), 64'(e_rsp_before));
        rst = 1'b0;
        #1;
        check({tag, " rsp_valid"}, 64'(rsp_valid), 64'h0);
        check({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'h0);
        check({tag, " ready"}, 64'(req_ready), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 2'b11;
        req_wen   = 2'b00;
        req_lock  = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst ready", 64'(req_ready), 64'h0);
        check("rst rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst ram_wen", 64'(ram_wen), 64'h0);
        check("rst ram_addr", 64'(ram_addr), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Preload two words, then the write/read-after-write pair.
        cyc("c1", 2'b11, 2'b11, 2'b00, 11'h010, 11'h020, 32'h11111111, 32'h22222222, 2'b01, 2'b00, 32'h0);
        cyc("c2", 2'b10, 2'b11, 2'b00, 11'h010, 11'h020, 32'h11111111, 32'h22222222, 2'b10, 2'b01, 32'h11111111);
        cyc("c3", 2'b01, 2'b01, 2'b00, 11'h0A5, 11'h020, 32'hDEADBEEF, 32'h0, 2'b01, 2'b10, 32'h22222222);
        cyc("c4", 2'b10, 2'b00, 2'b00, 11'h0A5, 11'h0A5, 32'h0, 32'h0, 2'b10, 2'b01, 32'hDEADBEEF);

        for (int k = 0; k < 8; k++) begin
            cyc("alt", 2'b11, 2'b00, 2'b00, 11'h010, 11'h020, 32'h0, 32'h0,
                (k % 2 == 0) ? 2'b01 : 2'b10,
                (k == 0) ? 2'b10 : ((k % 2 == 1) ? 2'b01 : 2'b10),
                (k == 0) ? 32'hDEADBEEF : ((k % 2 == 1) ? 32'h11111111 : 32'h22222222));
        end
        for (int k = 0; k < 3; k++) begin
            cyc("solo1", 2'b10, 2'b00, 2'b00, 11'h010, 11'h020, 32'h0, 32'h0, 2'b10, 2'b10, 32'h22222222);
        end
        cyc("both", 2'b11, 2'b00, 2'b00, 11'h010, 11'h020, 32'h0, 32'h0, 2'b01, 2'b10, 32'h22222222);
        cyc("idle", 2'b00, 2'b00, 2'b00, 11'h010, 11'h020, 32'h0, 32'h0, 2'b00, 2'b01, 32'h11111111);

`ifdef MEM_ARB_LOCK_EN
        cyc("L1", 2'b01, 2'b00, 2'b01, 11'h010, 11'h020, 32'h0, 32'h0, 2'b01, 2'b00, 32'h0);
        cyc("L2", 2'b10, 2'b00, 2'b00, 11'h010, 11'h020, 32'h0, 32'h0, 2'b00, 2'b01, 32'h11111111);
        cyc("L3", 2'b11, 2'b01, 2'b00, 11'h010, 11'h020, 32'h33333333, 32'h0, 2'b01, 2'b00, 32'h0);
        cyc("L4", 2'b10, 2'b00, 2'b00, 11'h010, 11'h020, 32'h0, 32'h0, 2'b10, 2'b01, 32'h33333333);
        cyc("L5", 2'b00, 2'b00, 2'b00, 11'h010, 11'h020, 32'h0, 32'h0, 2'b00, 2'b10, 32'h22222222);
`endif

        // Reset after a req0 grant: pointer must return to 0.
        cyc("R1", 2'b01, 2'b00, 2'b01, 11'h010, 11'h020, 32'h0, 32'h0, 2'b01, 2'b00, 32'h0);
        reset_now("rstA", 2'b01);
        cyc("P1", 2'b11, 2'b00, 2'b00, 11'h010, 11'h020, 32'h0, 32'h0, 2'b01, 2'b00, 32'h0);

`ifdef MEM_ARB_LOCK_EN
        // Reset while req0 holds the lock: req1 must be grantable afterwards.
        cyc("R2", 2'b01, 2'b00, 2'b01, 11'h010, 11'h020, 32'h0, 32'h0, 2'b01, 2'b01, 32'h33333333);
        reset_now("rstB", 2'b01);
        cyc("Q1", 2'b10, 2'b00, 2'b00, 11'h010, 11'h020, 32'h0, 32'h0, 2'b10, 2'b00, 32'h0);
        cyc("Q2", 2'b00, 2'b00, 2'b00, 11'h010, 11'h020, 32'h0, 32'h0, 2'b00, 2'b10, 32'h22222222);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
